// File: rtl/linescanner_pkg.sv
// Shared types and defaults for the line-scan sensor emulator: FSM encodings,
// parameter defaults and the pixel value stepping helper.
package linescanner_pkg;

    localparam int NUM_PIXELS_DEF  = 1024;
    localparam int CONV_CLOCKS_DEF = 64;
    localparam int LVAL_DELAY_DEF  = 2;
    localparam int PIX_W           = 11;

    typedef enum logic {
        ADC_IDLE    = 1'b0,
        ADC_CONVERT = 1'b1
    } adc_state_t;

    typedef enum logic [1:0] {
        RO_IDLE   = 2'd0,
        RO_DELAY  = 2'd1,
        RO_ACTIVE = 2'd2
    } ro_state_t;

    // Successive pixels of a line differ by one, modulo 256.
    function automatic logic [7:0] next_pixel(input logic [7:0] value);
        return value + 8'd1;
    endfunction

endpackage

// File: rtl/linescanner_sensor_emulator_if.sv
// Control and video bus between a capture front end (master) and the
// sensor emulator (slave).
interface linescanner_sensor_emulator_if;
    logic       rst_cvc;
    logic       rst_cds;
    logic       sample;
    logic       load_pulse;
    logic       end_adc;
    logic       lval;
    logic [7:0] data;
    logic       overrun;
    logic       protocol_error;

    modport master (
        output rst_cvc, rst_cds, sample, load_pulse,
        input  end_adc, lval, data, overrun, protocol_error
    );

    modport slave (
        input  rst_cvc, rst_cds, sample, load_pulse,
        output end_adc, lval, data, overrun, protocol_error
    );
endinterface

// File: rtl/linescanner_edge_detector.sv
// Registers the previous value of one control input and flags its rising
// and falling edges in the same cycle the new value is seen.
module linescanner_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev_r;

    // Previous-cycle copy of the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sig;
        end
    end

    assign rise = sig & ~prev_r;
    assign fall = ~sig & prev_r;

endmodule

// File: rtl/linescanner_sensor_emulator.sv
// Line-scan sensor emulator: converts a line after each exposure, then on
// load streams (line + pixel index) mod 256 with lval for NUM_PIXELS cycles.
module linescanner_sensor_emulator
    import linescanner_pkg::*;
#(
    parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
    parameter int CONV_CLOCKS = CONV_CLOCKS_DEF,
    parameter int LVAL_DELAY  = LVAL_DELAY_DEF
) (
    input logic                          pixel_clock,
    input logic                          reset,
    linescanner_sensor_emulator_if.slave bus
);

    localparam logic [7:0]       CONV_LAST = 8'(CONV_CLOCKS - 1);
    localparam logic [3:0]       DLY_LAST  = 4'(LVAL_DELAY - 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(NUM_PIXELS - 1);

    logic sample_rise_s, sample_fall_s, load_rise_s;
    logic cvc_rise_unused, cvc_fall_unused, cds_rise_unused, cds_fall_unused;
    logic load_fall_unused;

    linescanner_edge_detector u_edge_cvc (
        .clk(pixel_clock), .rst(reset), .sig(bus.rst_cvc),
        .rise(cvc_rise_unused), .fall(cvc_fall_unused)
    );
    linescanner_edge_detector u_edge_cds (
        .clk(pixel_clock), .rst(reset), .sig(bus.rst_cds),
        .rise(cds_rise_unused), .fall(cds_fall_unused)
    );
    linescanner_edge_detector u_edge_sample (
        .clk(pixel_clock), .rst(reset), .sig(bus.sample),
        .rise(sample_rise_s), .fall(sample_fall_s)
    );
    linescanner_edge_detector u_edge_load (
        .clk(pixel_clock), .rst(reset), .sig(bus.load_pulse),
        .rise(load_rise_s), .fall(load_fall_unused)
    );

    adc_state_t       adc_state_r, adc_state_s;
    ro_state_t        ro_state_r, ro_state_s;
    logic [7:0]       conv_cnt_r;
    logic [7:0]       line_cnt_r;
    logic [7:0]       buf_line_r;
    logic [7:0]       ro_line_r;
    logic [3:0]       dly_cnt_r;
    logic [PIX_W-1:0] pix_cnt_r;
    logic             end_adc_r, overrun_r, perr_r, lval_r;
    logic [7:0]       data_r;

    logic conv_restart_s, conv_done_s, conv_fe_err_s;
    logic load_accept_s, load_ignored_s, ro_start_s, ro_last_s, sample_err_s;

    // Next-state and strobe decode for both FSMs
    always_comb begin
        adc_state_s    = adc_state_r;
        ro_state_s     = ro_state_r;
        conv_restart_s = 1'b0;
        conv_done_s    = 1'b0;
        conv_fe_err_s  = 1'b0;
        ro_start_s     = 1'b0;
        ro_last_s      = 1'b0;
        load_accept_s  = load_rise_s & end_adc_r & (ro_state_r == RO_IDLE);
        load_ignored_s = load_rise_s & ~load_accept_s;
        sample_err_s   = sample_rise_s & (bus.rst_cvc | bus.rst_cds);

        case (adc_state_r)
            ADC_IDLE: begin
                if (sample_fall_s) begin
                    adc_state_s    = ADC_CONVERT;
                    conv_restart_s = 1'b1;
                end else begin
                    adc_state_s = ADC_IDLE;
                end
            end
            ADC_CONVERT: begin
                // A fresh exposure mid-conversion restarts it rather than completing
                if (sample_fall_s) begin
                    conv_restart_s = 1'b1;
                    conv_fe_err_s  = 1'b1;
                end else if (conv_cnt_r == CONV_LAST) begin
                    conv_done_s = 1'b1;
                    adc_state_s = ADC_IDLE;
                end else begin
                    adc_state_s = ADC_CONVERT;
                end
            end
            default: adc_state_s = ADC_CONVERT;
        endcase

        case (ro_state_r)
            RO_IDLE: begin
                if (load_accept_s) begin
                    ro_state_s = RO_DELAY;
                end else begin
                    ro_state_s = RO_IDLE;
                end
            end
            RO_DELAY: begin
                if (dly_cnt_r == DLY_LAST) begin
                    ro_state_s = RO_ACTIVE;
                    ro_start_s = 1'b1;
                end else begin
                    ro_state_s = RO_DELAY;
                end
            end
            RO_ACTIVE: begin
                if (pix_cnt_r == PIX_LAST) begin
                    ro_state_s = RO_IDLE;
                    ro_last_s  = 1'b1;
                end else begin
                    ro_state_s = RO_ACTIVE;
                end
            end
            default: ro_state_s = RO_IDLE;
        endcase
    end

    // State registers; reset starts the dummy conversion of line 0
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            adc_state_r <= ADC_CONVERT;
            ro_state_r  <= RO_IDLE;
        end else begin
            adc_state_r <= adc_state_s;
            ro_state_r  <= ro_state_s;
        end
    end

    // Conversion counter, line numbering and ADC buffer status
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            conv_cnt_r <= 8'd0;
            line_cnt_r <= 8'd0;
            buf_line_r <= 8'd0;
            end_adc_r  <= 1'b0;
            overrun_r  <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            if (conv_restart_s || conv_done_s) begin
                conv_cnt_r <= 8'd0;
            end else if (adc_state_r == ADC_CONVERT) begin
                conv_cnt_r <= conv_cnt_r + 8'd1;
            end
            // A simultaneous load takes the old buffer, so no overrun then
            if (conv_done_s) begin
                buf_line_r <= line_cnt_r;
                line_cnt_r <= line_cnt_r + 8'd1;
                end_adc_r  <= 1'b1;
                if (end_adc_r && !load_accept_s) begin
                    overrun_r <= 1'b1;
                end
            end else if (load_accept_s) begin
                end_adc_r <= 1'b0;
            end
            if (conv_fe_err_s || load_ignored_s || sample_err_s) begin
                perr_r <= 1'b1;
            end
        end
    end

    // Readout delay, pixel counting and the registered video outputs
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            dly_cnt_r <= 4'd0;
            pix_cnt_r <= '0;
            ro_line_r <= 8'd0;
            lval_r    <= 1'b0;
            data_r    <= 8'd0;
        end else begin
            if (load_accept_s) begin
                dly_cnt_r <= 4'd0;
                ro_line_r <= buf_line_r;
            end else if (ro_state_r == RO_DELAY) begin
                dly_cnt_r <= dly_cnt_r + 4'd1;
            end
            if (ro_start_s) begin
                pix_cnt_r <= '0;
                lval_r    <= 1'b1;
                data_r    <= ro_line_r;
            end else if (ro_last_s) begin
                lval_r <= 1'b0;
                data_r <= 8'd0;
            end else if (ro_state_r == RO_ACTIVE) begin
                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                data_r    <= next_pixel(data_r);
            end
        end
    end

    assign bus.end_adc        = end_adc_r;
    assign bus.lval           = lval_r;
    assign bus.data           = data_r;
    assign bus.overrun        = overrun_r;
    assign bus.protocol_error = perr_r;

endmodule

// File: tb/tb_linescanner_sensor_emulator.sv
// Randomized scoreboard bench for the line-scan sensor emulator; a timestamp
// reference model predicts lines, timing and the sticky flags.
module tb_linescanner_sensor_emulator;

    localparam int N    = 1024;
    localparam int CONV = 64;
    localparam int D    = 2;

    typedef struct {
        int line;
        int start;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    linescanner_sensor_emulator_if bif ();

    linescanner_sensor_emulator #(
        .NUM_PIXELS(N), .CONV_CLOCKS(CONV), .LVAL_DELAY(D)
    ) dut (
        .pixel_clock(clk),
        .reset(reset),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // Reference model state (edge-count timestamps)
    int   edge_n = 0;
    bit   m_conv_active, m_end_adc, m_ovr, m_perr;
    int   m_conv_end, m_line, m_buf, m_ro_free;
    bit   p_sample, p_load;
    exp_t exp_q[$];

    // Monitor state
    bit   in_line = 1'b0;
    int   pix = 0;
    exp_t cur;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: evaluated once per rising edge from the driven inputs
    initial begin
        bit s_re, s_fe, l_re, complete, accept;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                m_conv_active = 1'b1;
                m_conv_end    = edge_n + CONV;
                m_line = 0; m_buf = 0; m_ro_free = 0;
                m_end_adc = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
                p_sample = 1'b0; p_load = 1'b0;
            end else begin
                s_re = bif.sample && !p_sample;
                s_fe = !bif.sample && p_sample;
                l_re = bif.load_pulse && !p_load;
                complete = 1'b0;
                accept   = 1'b0;
                if (m_conv_active) begin
                    if (s_fe) begin
                        m_conv_end = edge_n + CONV;
                        m_perr = 1'b1;
                    end else if (edge_n == m_conv_end) begin
                        complete = 1'b1;
                        m_conv_active = 1'b0;
                    end
                end else if (s_fe) begin
                    m_conv_active = 1'b1;
                    m_conv_end = edge_n + CONV;
                end
                if (s_re && (bif.rst_cvc || bif.rst_cds)) m_perr = 1'b1;
                if (l_re) begin
                    if (m_end_adc && edge_n >= m_ro_free) begin
                        accept = 1'b1;
                        exp_q.push_back('{line: m_buf, start: edge_n + D});
                        m_ro_free = edge_n + D + N + 1;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                if (complete) begin
                    if (m_end_adc && !accept) m_ovr = 1'b1;
                    m_buf  = m_line;
                    m_line = (m_line + 1) % 256;
                    m_end_adc = 1'b1;
                end else if (accept) begin
                    m_end_adc = 1'b0;
                end
                p_sample = bif.sample;
                p_load   = bif.load_pulse;
            end
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_lval", int'(bif.lval), 0);
                chk("rst_data", int'(bif.data), 0);
                chk("rst_end_adc", int'(bif.end_adc), 0);
                chk("rst_flags", int'({bif.overrun, bif.protocol_error}), 0);
                exp_q.delete();
                in_line = 1'b0;
            end else begin
                chk("end_adc", int'(bif.end_adc), int'(m_end_adc));
                chk("overrun", int'(bif.overrun), int'(m_ovr));
                chk("protocol_error", int'(bif.protocol_error), int'(m_perr));
                if (bif.lval) begin
                    if (!in_line) begin
                        if (exp_q.size() == 0) begin
                            chk("lval_unexpected", 1, 0);
                            cur = '{line: 0, start: edge_n};
                        end else begin
                            cur = exp_q.pop_front();
                            chk("lval_start", edge_n, cur.start);
                        end
                        in_line = 1'b1;
                        pix = 0;
                    end
                    chk("pixel", int'(bif.data), (cur.line + pix) % 256);
                    pix++;
                end else begin
                    chk("data_idle", int'(bif.data), 0);
                    if (in_line) begin
                        chk("lval_len", pix, N);
                        in_line = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_load();
        bif.load_pulse = 1'b1; tick();
        bif.load_pulse = 1'b0; tick();
    endtask

    task automatic pulse_sample();
        bif.sample = 1'b1; tick();
        bif.sample = 1'b0; tick();
    endtask

    task automatic wait_ro();
        int guard = 0;
        while (edge_n < m_ro_free && guard < 5000) begin
            tick();
            guard++;
        end
        if (guard >= 5000) chk("readout_timeout", guard, 0);
        tick();
    endtask

    task automatic capture_line();
        wait_ro();
        bif.rst_cvc = 1'b1; tick();
        bif.rst_cvc = 1'b0; tick();
        bif.rst_cds = 1'b1; tick();
        bif.rst_cds = 1'b0; tick();
        pulse_sample();
        repeat (CONV + 2) tick();
        pulse_load();
    endtask

    initial begin
        int guard;
        bif.rst_cvc = 1'b0; bif.rst_cds = 1'b0;
        bif.sample  = 1'b0; bif.load_pulse = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (CONV + 6) tick();

        // Dummy line 0, then a captured line 1
        pulse_load();
        capture_line();
        wait_ro();

        // Load with nothing converted, then a second load during readout
        pulse_load();
        capture_line();
        repeat (300) tick();
        pulse_load();
        wait_ro();

        // Randomized mix of operations
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 4))
                0: begin capture_line(); end
                1: begin pulse_sample(); repeat ($urandom_range(0, 100)) tick(); end
                2: begin pulse_load(); repeat ($urandom_range(0, 300)) tick(); end
                3: begin
                    if ($urandom_range(0, 1) == 0) bif.rst_cvc = 1'b1;
                    else bif.rst_cds = 1'b1;
                    tick();
                    pulse_sample();
                    bif.rst_cvc = 1'b0; bif.rst_cds = 1'b0; tick();
                end
                default: repeat ($urandom_range(0, 200)) tick();
            endcase
        end
        wait_ro();

        // Convert without loading until line 255 is buffered (overruns), then wrap
        guard = 0;
        while (!(m_end_adc && m_buf == 255) && guard < 300) begin
            pulse_sample();
            repeat (CONV + 3) tick();
            guard++;
        end
        if (guard >= 300) chk("wrap_timeout", guard, 0);
        pulse_load();
        capture_line();
        wait_ro();

        // Reset in the middle of a readout
        pulse_sample();
        repeat (CONV + 3) tick();
        pulse_load();
        repeat (D + 500) tick();
        chk("lval_before_reset", int'(bif.lval), 1);
        reset = 1'b1;
        #1;
        chk("abort_lval", int'(bif.lval), 0);
        chk("abort_data", int'(bif.data), 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (CONV + 6) tick();
        capture_line();
        wait_ro();

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("line_closed", int'(in_line), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linescanner_sensor_emulator.md
LINESCANNER_SENSOR_EMULATOR -- requirements
Module: linescanner_sensor_emulator

Interface
REQ-001 Parameter NUM_PIXELS, default 1024: pixels per line; legal range 2..2048.
REQ-002 Parameter CONV_CLOCKS, default 64: ADC conversion length in pixel_clock cycles; legal range 2..255.
REQ-003 Parameter LVAL_DELAY, default 2: cycles from load_pulse rising edge to the first valid pixel; legal range 1..15.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 pixel_clock  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rst_cvc  input  1  sensor CVC reset from the capture side.
REQ-008 rst_cds  input  1  sensor CDS reset from the capture side.
REQ-009 sample  input  1  exposure sample strobe.
REQ-010 load_pulse  input  1  request to move the converted line to readout.
REQ-011 end_adc  output  1  converted line is held in the ADC buffer.
REQ-012 lval  output  1  line valid, high for exactly NUM_PIXELS cycles per readout.
REQ-013 data  output  8  pixel value; 0 whenever lval=0.
REQ-014 overrun  output  1  sticky: a conversion completed while end_adc=1.
REQ-015 protocol_error  output  1  sticky: a control-sequence violation occurred.

Function
REQ-016 All inputs are synchronous to pixel_clock.
  - Previous-cycle copies are registered.
  - RE = current 1 and previous 0; FE = current 0 and previous 1; both are evaluated at the same edge.
REQ-017 ADC FSM states: ADC_IDLE, ADC_CONVERT.
  - After reset release it enters ADC_CONVERT (dummy conversion, line number 0).
REQ-018 ADC_IDLE -> ADC_CONVERT on sample FE; the conversion counter loads 0.
REQ-019 ADC_CONVERT completes CONV_CLOCKS edges after entry, then:
  - end_adc goes to 1 and the conversion counter clears;
  - buffered line number becomes the current 8-bit line counter;
  - line counter increments, wrapping 255->0;
  - FSM returns to ADC_IDLE.
REQ-020 Sample FE during ADC_CONVERT restarts the conversion counter and sets protocol_error.
REQ-021 Completion while end_adc=1 without a load RE at that edge: buffer is overwritten, end_adc stays 1, overrun is set.
REQ-022 Sample RE while rst_cvc=1 or rst_cds=1 sets protocol_error; the sequencing is otherwise unaffected.
REQ-023 Readout FSM states: RO_IDLE, RO_DELAY, RO_ACTIVE.
REQ-024 On load_pulse RE in RO_IDLE with end_adc=1:
  - readout line number is latched from the buffer;
  - end_adc clears at that edge, unless a conversion completes at the same edge (REQ-019 sets it, no overrun);
  - FSM enters RO_DELAY.
REQ-025 After RO_DELAY, lval=1 with pixel 0 on data at the output after edge L+LVAL_DELAY, where L is the load edge.
REQ-026 In RO_ACTIVE, data = (readout line + pixel index) mod 256, pixel index 0..NUM_PIXELS-1.
  - After the last pixel, lval=0 and data=0, and the FSM returns to RO_IDLE.
  - lval is low for at least 1 cycle between lines.
REQ-027 A load_pulse RE that is ignored sets protocol_error; ignored means either:
  - load RE with end_adc=0; or
  - load RE outside RO_IDLE.
REQ-028 Pixel counter width is 11 bits; line and pixel arithmetic is truncated to 8 bits.
REQ-029 All outputs are registered; no combinational input-to-output path.

Reset
REQ-030 While reset=1, asynchronously:
  - end_adc, lval, overrun and protocol_error are 0, and data=0;
  - FSMs are in ADC_CONVERT and RO_IDLE;
  - all counters and previous-value registers are 0.
REQ-031 Reset asserted mid-readout or mid-conversion aborts immediately; there is no partial line after release.
REQ-032 overrun and protocol_error clear only by reset.

Structure
REQ-033 The ADC and readout state encodings and the parameter defaults are defined in shared package linescanner_pkg.
REQ-034 A single sub-module, linescanner_edge_detector, instantiated once per control input, provides the RE/FE strobes.

Verification
REQ-035 Reset release, CONV_CLOCKS=64 -> end_adc=1 after edge 64; overrun=0, protocol_error=0.
REQ-036 Load RE at edge L, LVAL_DELAY=2, NUM_PIXELS=1024 ->
  - end_adc=0 after L;
  - lval high after L+2 for exactly 1024 cycles;
  - data 0,1,..,255,0,.. for line 0.
REQ-037 Capture-style full loop (rst_cvc FE, rst_cds FE, sample RE/FE, load) ->
  - second line data starts at 1;
  - line counter at 255 wraps so the next line starts at 0.
REQ-038 Sample FE, then no load for 2x CONV_CLOCKS, then sample FE again -> overrun=1 after the second completion; end_adc stays 1.
REQ-039 Load RE with end_adc=0, and a second load during RO_ACTIVE -> protocol_error=1; lval pattern unaffected.
REQ-040 Reset asserted at pixel 500 of a readout -> lval=0 and data=0 immediately; end_adc rises again CONV_CLOCKS after release.
